// File: rtl/alu_secuencial.sv
// Multi-cycle ALU with a start/valid/busy handshake and registered zero/carry flags.
// Simple ops take one cycle in CALC. MUL is a shift-add loop that takes N cycles.
module alu_secuencial #(
    parameter int unsigned N = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     ALUA,
    input  logic [N-1:0]     ALUB,
    input  logic [2:0]       op_sel,
    input  logic             ALUiniciar,
    output logic [2*N-1:0]   ALUResult,
    output logic             ALUvalido,
    output logic             ALUocupado,
    output logic             ALUcero,
    output logic             ALUacarreo
);

    localparam int unsigned RES_W = 2 * N;
    localparam int unsigned EXT_W = N + 1;
    localparam int unsigned CNT_W = $clog2(N);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {IDLE, CALC} state_t;

    state_t            state_q, state_d;
    logic [N-1:0]      a_q, a_d, b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RES_W-1:0]  acc_q, acc_d;
    logic [RES_W-1:0]  res_d;
    logic              valido_d, ocupado_d, cero_d, carry_d;

    logic [EXT_W-1:0]  sum, diff, shl_ext;
    logic [RES_W-1:0]  simple_res, mul_term, mul_sum;
    logic              simple_carry;

    // Single-cycle datapath for the non-multiply ops, driven from the latched operands
    always_comb begin
        sum          = {1'b0, a_q} + {1'b0, b_q};
        diff         = {1'b0, a_q} - {1'b0, b_q};
        // Bit N of the widened shift is the last bit shifted out. It is 0 for B=0 and for B>N.
        shl_ext      = EXT_W'(a_q) << b_q;
        simple_res   = '0;
        simple_carry = 1'b0;
        case (op_q)
            OP_AND: simple_res = RES_W'(a_q & b_q);
            OP_OR:  simple_res = RES_W'(a_q | b_q);
            OP_ADD: begin
                simple_res   = RES_W'(sum);
                simple_carry = sum[N];
            end
            OP_SUB: begin
                simple_res   = RES_W'(diff[N-1:0]);
                simple_carry = diff[N];
            end
            OP_XOR: simple_res = RES_W'(a_q ^ b_q);
            OP_SHL: begin
                simple_res   = RES_W'(shl_ext[N-1:0]);
                simple_carry = shl_ext[N];
            end
            OP_SHR: simple_res = RES_W'(a_q >> b_q);
            default: ;
        endcase
    end

    // Partial product for the multiplier bit selected by the iteration count
    always_comb begin
        mul_term = b_q[cnt_q] ? (RES_W'(a_q) << cnt_q) : '0;
        mul_sum  = acc_q + mul_term;
    end

    // Next-state and next register values. Operands are accepted only in IDLE.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        res_d     = ALUResult;
        valido_d  = 1'b0;
        ocupado_d = ALUocupado;
        cero_d    = ALUcero;
        carry_d   = ALUacarreo;
        case (state_q)
            IDLE: begin
                if (ALUiniciar) begin
                    a_d       = ALUA;
                    b_d       = ALUB;
                    op_d      = op_sel;
                    cnt_d     = '0;
                    acc_d     = '0;
                    ocupado_d = 1'b1;
                    state_d   = CALC;
                end
            end
            CALC: begin
                if (op_q == OP_MUL) begin
                    acc_d = mul_sum;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N - 1)) begin
                        res_d     = mul_sum;
                        cero_d    = (mul_sum == '0);
                        carry_d   = 1'b0;
                        valido_d  = 1'b1;
                        ocupado_d = 1'b0;
                        state_d   = IDLE;
                    end
                end else begin
                    res_d     = simple_res;
                    cero_d    = (simple_res == '0);
                    carry_d   = simple_carry;
                    valido_d  = 1'b1;
                    ocupado_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand and output registers. Reset wins over a completion on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            ALUResult  <= '0;
            ALUvalido  <= 1'b0;
            ALUocupado <= 1'b0;
            ALUcero    <= 1'b0;
            ALUacarreo <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            ALUResult  <= res_d;
            ALUvalido  <= valido_d;
            ALUocupado <= ocupado_d;
            ALUcero    <= cero_d;
            ALUacarreo <= carry_d;
        end
    end

endmodule

// File: tb/tb_alu_secuencial.sv
// Self-checking bench for alu_secuencial with N=7: directed table, corner sequences, random ops.
module tb_alu_secuencial;

    localparam int NW = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic [NW-1:0]     ALUA, ALUB;
    logic [2:0]        op_sel;
    logic              ALUiniciar;
    logic [2*NW-1:0]   ALUResult;
    logic              ALUvalido, ALUocupado, ALUcero, ALUacarreo;

    int n_checks = 0;
    int n_fail   = 0;

    alu_secuencial #(.N(NW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ALUA       (ALUA),
        .ALUB       (ALUB),
        .op_sel     (op_sel),
        .ALUiniciar (ALUiniciar),
        .ALUResult  (ALUResult),
        .ALUvalido  (ALUvalido),
        .ALUocupado (ALUocupado),
        .ALUcero    (ALUcero),
        .ALUacarreo (ALUacarreo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]      op;
        logic [NW-1:0]   a;
        logic [NW-1:0]   b;
        logic [2*NW-1:0] res;
        logic            carry;
        logic            zero;
        int              lat;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference behaviour from the op definitions, using plain integer arithmetic
    function automatic void model(input int op, input int a, input int b,
                                  output int r, output int c);
        int m;
        m = 1 << NW;
        c = 0;
        case (op)
            0: r = a & b;
            1: r = a | b;
            2: begin r = a + b; c = (r >= m) ? 1 : 0; end
            3: begin r = (a - b + m) % m; c = (a < b) ? 1 : 0; end
            4: r = a ^ b;
            5: begin
                r = (b >= NW) ? 0 : ((a * (1 << b)) % m);
                c = (b >= 1 && b <= NW) ? ((a >> (NW - b)) & 1) : 0;
            end
            6: r = (b >= NW) ? 0 : (a / (1 << b));
            default: r = a * b;
        endcase
    endfunction

    // Issue one op and wait for its pulse. Operands are scrambled while busy, with an optional start request.
    task automatic run_op(input logic [2:0] op, input logic [NW-1:0] a, input logic [NW-1:0] b,
                          input bit poke, output logic [2*NW-1:0] res, output logic c,
                          output logic z, output int lat);
        bit seen;
        ALUA = a; ALUB = b; op_sel = op; ALUiniciar = 1'b1;
        @(posedge clk); #1;
        chk("ocupado_after_accept", 32'(ALUocupado), 32'd1);
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            ALUA = NW'($urandom); ALUB = NW'($urandom);
            op_sel = poke ? 3'b000 : 3'($urandom);
            ALUiniciar = poke;
            @(posedge clk); #1;
            lat++;
            if (ALUvalido) seen = 1'b1;
            else chk("ocupado_while_busy", 32'(ALUocupado), 32'd1);
        end
        ALUiniciar = 1'b0;
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL valido_timeout: got no pulse expected pulse within 40 cycles");
        end
        chk("ocupado_at_valido", 32'(ALUocupado), 32'd0);
        res = ALUResult; c = ALUacarreo; z = ALUcero;
        @(posedge clk); #1;
        chk("valido_single_cycle", 32'(ALUvalido), 32'd0);
        chk("idle_after_done", 32'(ALUocupado), 32'd0);
    endtask

    task automatic expect_op(input string name, input logic [2:0] op, input logic [NW-1:0] a,
                             input logic [NW-1:0] b, input bit poke, input logic [2*NW-1:0] eres,
                             input logic ec, input logic ez, input int elat);
        logic [2*NW-1:0] r; logic c, z; int lat;
        run_op(op, a, b, poke, r, c, z, lat);
        chk({name, "_result"},  32'(r),   32'(eres));
        chk({name, "_carry"},   32'(c),   32'(ec));
        chk({name, "_zero"},    32'(z),   32'(ez));
        chk({name, "_latency"}, 32'(lat), 32'(elat));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int r, c;
        logic [2:0] rop; logic [NW-1:0] ra, rb;

        //            op      a      b      res       c     z     lat
        vecs[0]  = '{3'b010, 7'd100, 7'd50, 14'h0096, 1'b1, 1'b0, 1};
        vecs[1]  = '{3'b011, 7'd5,   7'd9,  14'h007C, 1'b1, 1'b0, 1};
        vecs[2]  = '{3'b011, 7'd9,   7'd9,  14'h0000, 1'b0, 1'b1, 1};
        vecs[3]  = '{3'b101, 7'h41,  7'd1,  14'h0002, 1'b1, 1'b0, 1};
        vecs[4]  = '{3'b101, 7'h7F,  7'd7,  14'h0000, 1'b1, 1'b1, 1};
        vecs[5]  = '{3'b110, 7'h7F,  7'd3,  14'h000F, 1'b0, 1'b0, 1};
        vecs[6]  = '{3'b000, 7'h55,  7'h0F, 14'h0005, 1'b0, 1'b0, 1};
        vecs[7]  = '{3'b001, 7'h50,  7'h05, 14'h0055, 1'b0, 1'b0, 1};
        vecs[8]  = '{3'b100, 7'h7F,  7'h0F, 14'h0070, 1'b0, 1'b0, 1};
        vecs[9]  = '{3'b010, 7'd127, 7'd127,14'h00FE, 1'b1, 1'b0, 1};
        vecs[10] = '{3'b101, 7'h7F,  7'd9,  14'h0000, 1'b0, 1'b1, 1};
        vecs[11] = '{3'b111, 7'd0,   7'd100,14'h0000, 1'b0, 1'b1, 7};
        vecs[12] = '{3'b111, 7'd5,   7'd3,  14'h000F, 1'b0, 1'b0, 7};
        vecs[13] = '{3'b110, 7'h40,  7'd0,  14'h0040, 1'b0, 1'b0, 1};
        vecs[14] = '{3'b101, 7'h01,  7'd0,  14'h0001, 1'b0, 1'b0, 1};
        vecs[15] = '{3'b011, 7'd0,   7'd127,14'h0001, 1'b1, 1'b0, 1};

        rst = 1'b1; ALUiniciar = 1'b0; ALUA = '0; ALUB = '0; op_sel = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_result",  32'(ALUResult),  32'd0);
        chk("reset_valido",  32'(ALUvalido),  32'd0);
        chk("reset_ocupado", 32'(ALUocupado), 32'd0);
        chk("reset_cero",    32'(ALUcero),    32'd0);
        chk("reset_carry",   32'(ALUacarreo), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++)
            expect_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 1'b0,
                      vecs[i].res, vecs[i].carry, vecs[i].zero, vecs[i].lat);

        // MUL with start requests arriving mid-operation. They must be ignored.
        expect_op("mul_max_poke", 3'b111, 7'd127, 7'd127, 1'b1, 14'h3F01, 1'b0, 1'b0, 7);

        // Reset on the third CALC edge of a MUL aborts it and clears the previous result.
        ALUA = 7'd3; ALUB = 7'd5; op_sel = 3'b111; ALUiniciar = 1'b1;
        @(posedge clk); #1;
        ALUiniciar = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_result",  32'(ALUResult),  32'd0);
        chk("midrst_valido",  32'(ALUvalido),  32'd0);
        chk("midrst_ocupado", 32'(ALUocupado), 32'd0);
        chk("midrst_cero",    32'(ALUcero),    32'd0);
        chk("midrst_carry",   32'(ALUacarreo), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_pulse", 32'({ALUvalido, ALUocupado}), 32'd0);
        end
        expect_op("or_after_rst", 3'b001, 7'h50, 7'h05, 1'b0, 14'h0055, 1'b0, 1'b0, 1);

        // Back-to-back: start held high through the valid cycle is accepted immediately.
        ALUA = 7'h7F; ALUB = 7'h0F; op_sel = 3'b100; ALUiniciar = 1'b1;
        @(posedge clk); #1;
        ALUA = 7'h3C; ALUB = 7'h0F; op_sel = 3'b000;
        @(posedge clk); #1;
        chk("b2b_first_valido", 32'(ALUvalido), 32'd1);
        chk("b2b_first_result", 32'(ALUResult), 32'h70);
        @(posedge clk); #1;
        ALUiniciar = 1'b0;
        chk("b2b_gap_valido",   32'(ALUvalido),  32'd0);
        chk("b2b_gap_ocupado",  32'(ALUocupado), 32'd1);
        @(posedge clk); #1;
        chk("b2b_second_valido", 32'(ALUvalido), 32'd1);
        chk("b2b_second_result", 32'(ALUResult), 32'h0C);
        @(posedge clk); #1;
        chk("b2b_end_valido", 32'(ALUvalido), 32'd0);

        // Random ops against the reference model
        for (int i = 0; i < 300; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = NW'($urandom);
            rb  = ($urandom_range(0, 1) == 0) ? NW'($urandom_range(0, 9)) : NW'($urandom);
            model(int'(rop), int'(ra), int'(rb), r, c);
            expect_op($sformatf("rnd%0d_op%0d_a%0h_b%0h", i, rop, ra, rb), rop, ra, rb,
                      ($urandom_range(0, 3) == 0), (2*NW)'(r), c[0], (r == 0),
                      (rop == 3'b111) ? NW : 1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
